uart_tx_drain_ctrl: RTL
=======================

// Module: uart_tx_drain_ctrl
// PURPOSE
//   Sequences the TX FIFO into the UART transmit serializer. It pops one word at a time
//   from the first-word-fall-through FIFO, hands the word to the serializer with a
//   start/done handshake, and inserts a programmable idle gap between frames.
//   It also implements FIFO flush, a frame counter and a sticky TX-empty interrupt.
// PARAMETERS
//   DATA_WIDTH  8   FIFO and serializer data width
//   GAP_WIDTH   8   width of the inter-frame gap counter
//   CNT_WIDTH   16  width of the frames_sent counter
// PORTS
//   clk          in   1           single clock; all logic is posedge clk
//   rst_n        in   1           synchronous, active-low reset
//   en           in   1           drain enable
//   gap_cycles   in   GAP_WIDTH   idle cycles after each tx_done; 0 = back-to-back
//   flush        in   1           request to discard the FIFO contents
//   irq_clr      in   1           clears irq_empty
//   fifo_empty   in   1           FIFO empty flag
//   fifo_rd_data in   DATA_WIDTH  FIFO head word (combinational, valid while !fifo_empty)
//   fifo_rd      out  1           FIFO pop strobe; one pop per asserted cycle
//   tx_ready     in   1           serializer idle
//   tx_start     out  1           one-cycle start pulse to the serializer
//   tx_data      out  DATA_WIDTH  frame data; stable from tx_start until tx_done
//   tx_done      in   1           one-cycle end-of-frame pulse from the serializer
//   busy         out  1           1 whenever state != IDLE
//   frames_sent  out  CNT_WIDTH   count of completed frames; wraps modulo 2^CNT_WIDTH
//   irq_empty    out  1           sticky: last frame finished with the FIFO empty
// BEHAVIOUR
//   Reset (rst_n=0 sampled at posedge clk)
//     - state=IDLE; fifo_rd=0, tx_start=0, tx_data=0, busy=0, frames_sent=0,
//       irq_empty=0, flush_pend=0.
//     - Reset mid-frame aborts the sequence immediately. No pop or start is issued
//       in the reset cycle.
//   FSM states: IDLE, FETCH, START, WAIT, GAP, FLUSH.
//     - IDLE -> FLUSH when flush_pend|flush. This takes priority over the next rule.
//     - IDLE -> FETCH when en & !fifo_empty & tx_ready.
//     - FETCH: fifo_rd=1 (combinational, this cycle only); tx_data <= fifo_rd_data.
//       Always goes to START.
//     - START: tx_start=1 for exactly one cycle; goes to WAIT.
//     - WAIT: wait for tx_done. On tx_done: frames_sent += 1, then:
//         - flush_pend -> FLUSH;
//         - else gap_cycles==0 -> IDLE;
//         - else GAP with gap_cnt <= gap_cycles.
//     - GAP: gap_cnt decrements each cycle. When gap_cnt==1 -> IDLE, so exactly
//       gap_cycles cycles are spent in GAP. flush (or flush_pend) in GAP -> FLUSH.
//     - FLUSH: fifo_rd = !fifo_empty every cycle. When fifo_empty -> IDLE and
//       flush_pend <= 0.
//   Latency and handshake
//     - From the IDLE cycle in which the entry condition holds: fifo_rd is high
//       1 cycle later (FETCH) and tx_start 2 cycles later (START).
//     - fifo_rd is never asserted while fifo_empty=1.
//     - tx_done is ignored outside WAIT.
//     - tx_data holds its last value outside FETCH.
//   flush
//     - flush in FETCH, START or WAIT sets flush_pend.
//     - The frame in flight always completes, then the FSM drains the FIFO.
//   en
//     - en=0 only blocks the IDLE->FETCH transition. A frame in progress runs to
//       completion, including its gap.
//   irq_empty
//     - Set on tx_done in WAIT when fifo_empty=1.
//     - Cleared by irq_clr. If set and irq_clr occur in the same cycle, set wins.
//   frames_sent
//     - Counts every tx_done in WAIT, including the frame that completes before a flush.
//     - 2^CNT_WIDTH-1 + 1 wraps to 0.
// TESTING
//   1. FIFO holds 0xA5, en=1, tx_ready=1, gap=0:
//      fifo_rd at t+1, tx_start and tx_data=0xA5 at t+2; tx_done gives
//      frames_sent=1 and irq_empty=1.
//   2. 3 words queued, gap_cycles=4:
//      three frames sent in FIFO order; exactly 4 busy idle cycles between each
//      tx_done and the next FETCH.
//   3. flush pulsed during WAIT with 5 words queued:
//      the current frame completes; then 5 consecutive fifo_rd pulses with no tx_start;
//      fifo_empty; IDLE.
//   4. en dropped during START:
//      the frame completes; no further FETCH while en=0 even with data queued;
//      reasserting en resumes.
//   5. irq_clr and set-condition in the same cycle -> irq_empty stays 1;
//      irq_clr alone -> 0.
//      frames_sent at 0xFFFF plus one frame -> 0x0000.
//   6. rst_n=0 during WAIT:
//      next cycle all outputs are at reset values; a stray tx_done afterwards is ignored.

Source files
------------

// File: rtl/uart_tx_drain_ctrl_if.sv
// FIFO-read and serializer handshake bundle between the drain controller and its neighbours.
interface uart_tx_drain_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_rd;
  logic                  tx_ready;
  logic                  tx_start;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_done;

  modport master (
    input  fifo_empty, fifo_rd_data, tx_ready, tx_done,
    output fifo_rd, tx_start, tx_data
  );

  modport slave (
    output fifo_empty, fifo_rd_data, tx_ready, tx_done,
    input  fifo_rd, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_drain_ctrl.sv
// Drains a FWFT TX FIFO into the UART serializer, one frame at a time, with an
// optional idle gap between frames, FIFO flush, frame counter and sticky empty IRQ.
//
// state   | meaning
// --------+----------------------------------------------------
// S_IDLE  | waiting for data + enable + serializer ready, or a flush
// S_FETCH | pop the FIFO head and latch it as frame data
// S_START | one-cycle start pulse to the serializer
// S_WAIT  | frame in flight, waiting for tx_done
// S_GAP   | inter-frame idle time, gap_cnt counts down to 1
// S_FLUSH | popping the FIFO until empty
module uart_tx_drain_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int GAP_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [GAP_WIDTH-1:0] gap_cycles,
  input  logic                 flush,
  input  logic                 irq_clr,
  uart_tx_drain_ctrl_if.master bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] frames_sent,
  output logic                 irq_empty
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_WAIT,
    S_GAP,
    S_FLUSH
  } state_t;

  state_t                state, state_nxt;
  logic [GAP_WIDTH-1:0]  gap_cnt, gap_cnt_nxt;
  logic                  flush_pend, flush_pend_nxt;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  fifo_rd_c;
  logic                  tx_start_c;
  logic                  frame_done;

  assign frame_done = (state == S_WAIT) && bus.tx_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      gap_cnt    <= '0;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      gap_cnt    <= gap_cnt_nxt;
      flush_pend <= flush_pend_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    gap_cnt_nxt    = gap_cnt;
    flush_pend_nxt = flush_pend;
    fifo_rd_c      = 1'b0;
    tx_start_c     = 1'b0;
    case (state)
      S_IDLE: begin
        if (flush_pend || flush)
          state_nxt = S_FLUSH;
        else if (en && !bus.fifo_empty && bus.tx_ready)
          state_nxt = S_FETCH;
      end
      S_FETCH: begin
        fifo_rd_c = !bus.fifo_empty;
        if (flush) flush_pend_nxt = 1'b1;
        state_nxt = S_START;
      end
      S_START: begin
        tx_start_c = 1'b1;
        if (flush) flush_pend_nxt = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (flush) flush_pend_nxt = 1'b1;
        // a flush arriving together with tx_done still counts as pending
        if (bus.tx_done) begin
          if (flush_pend || flush) begin
            state_nxt = S_FLUSH;
          end else if (gap_cycles == '0) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt   = S_GAP;
            gap_cnt_nxt = gap_cycles;
          end
        end
      end
      S_GAP: begin
        if (flush || flush_pend)
          state_nxt = S_FLUSH;
        else if (gap_cnt == GAP_WIDTH'(1))
          state_nxt = S_IDLE;
        else
          gap_cnt_nxt = gap_cnt - GAP_WIDTH'(1);
      end
      S_FLUSH: begin
        fifo_rd_c = !bus.fifo_empty;
        if (bus.fifo_empty) begin
          state_nxt      = S_IDLE;
          flush_pend_nxt = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_data_q   <= '0;
      frames_sent <= '0;
      irq_empty   <= 1'b0;
    end else begin
      if (state == S_FETCH) tx_data_q <= bus.fifo_rd_data;
      if (frame_done) frames_sent <= frames_sent + CNT_WIDTH'(1);
      if (frame_done && bus.fifo_empty)
        irq_empty <= 1'b1;
      else if (irq_clr)
        irq_empty <= 1'b0;
    end
  end

  // strobes are masked in the reset cycle so an aborted frame never pops or starts
  assign bus.fifo_rd  = fifo_rd_c & rst_n;
  assign bus.tx_start = tx_start_c & rst_n;
  assign bus.tx_data  = tx_data_q;
  assign busy         = (state != S_IDLE);

endmodule
